// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller.
// Cell and winner codes, FSM encoding and the board slice helper.
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        S_TURN,
        S_CHECK,
        S_OVER
    } state_e;

    // Cell 0 sits in the top bits; returns the low bit of the 2-bit slice.
    function automatic logic [4:0] cell_lo(input logic [3:0] idx);
        return 5'(5'd16 - {idx, 1'b0});
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: any of the 8 lines fully owned by one code.
// Empty code never wins.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  code,
    output logic        win
);

    logic [8:0] own;

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_own
        assign own[i] = (board[cell_lo(4'(i)) +: 2] == code)
                      && (code != CELL_EMPTY);
    end

    assign win = (own[0] & own[1] & own[2])
               | (own[3] & own[4] & own[5])
               | (own[6] & own[7] & own[8])
               | (own[0] & own[3] & own[6])
               | (own[1] & own[4] & own[7])
               | (own[2] & own[5] & own[8])
               | (own[0] & own[4] & own[8])
               | (own[2] & own[4] & own[6]);

endmodule

// File: rtl/ttt_game_ctrl.sv
// Turn sequencer for tic-tac-toe: validates moves, owns the board,
// and declares a win or draw one cycle after each accepted move.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        p1_req,
    input  logic [3:0]  p1_cell,
    input  logic        p2_req,
    input  logic [3:0]  p2_cell,
    output logic        p1_ack,
    output logic        p2_ack,
    output logic        p1_err,
    output logic        p2_err,
    output logic [17:0] board,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        over_q, over_d;
    logic [1:0]  winner_q, winner_d;
    logic        p1_ack_q, p1_ack_d;
    logic        p2_ack_q, p2_ack_d;
    logic        p1_err_q, p1_err_d;
    logic        p2_err_q, p2_err_d;

    logic        cur_req;
    logic        oth_req;
    logic [3:0]  cur_cell;
    logic        cell_in_range;
    logic [4:0]  lo;
    logic        cell_free;
    logic [1:0]  mover_code;
    logic        mover_wins;

    assign cur_req    = turn_q ? p2_req : p1_req;
    assign oth_req    = turn_q ? p1_req : p2_req;
    assign cur_cell   = turn_q ? p2_cell : p1_cell;
    assign mover_code = turn_q ? CELL_O : CELL_X;

    // Out-of-range cells are remapped so the slice read stays on the board.
    assign cell_in_range = cur_cell < 4'(NUM_CELLS);
    assign lo            = cell_lo(cell_in_range ? cur_cell : 4'd0);
    assign cell_free     = cell_in_range
                         && (board_q[lo +: 2] == CELL_EMPTY);

    ttt_line_check u_line_check (
        .board (board_q),
        .code  (mover_code),
        .win   (mover_wins)
    );

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        cnt_d    = cnt_q;
        over_d   = over_q;
        winner_d = winner_q;
        p1_ack_d = 1'b0;
        p2_ack_d = 1'b0;
        p1_err_d = 1'b0;
        p2_err_d = 1'b0;

        if (new_game) begin
            state_d  = S_TURN;
            board_d  = '0;
            turn_d   = FIRST_PLAYER;
            cnt_d    = '0;
            over_d   = 1'b0;
            winner_d = WIN_NONE;
        end else begin
            unique case (state_q)
                S_TURN: begin
                    if (cur_req) begin
                        if (cell_free) begin
                            board_d[lo +: 2] = mover_code;
                            cnt_d   = cnt_q + 4'd1;
                            state_d = S_CHECK;
                            if (turn_q) p2_ack_d = 1'b1;
                            else        p1_ack_d = 1'b1;
                        end else begin
                            if (turn_q) p2_err_d = 1'b1;
                            else        p1_err_d = 1'b1;
                        end
                    end
                    if (oth_req) begin
                        if (turn_q) p1_err_d = 1'b1;
                        else        p2_err_d = 1'b1;
                    end
                end
                S_CHECK: begin
                    p1_err_d = p1_req;
                    p2_err_d = p2_req;
                    if (mover_wins) begin
                        over_d   = 1'b1;
                        winner_d = turn_q ? WIN_P2 : WIN_P1;
                        state_d  = S_OVER;
                    end else if (cnt_q == 4'(NUM_CELLS)) begin
                        over_d   = 1'b1;
                        winner_d = WIN_DRAW;
                        state_d  = S_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_TURN;
                    end
                end
                S_OVER: begin
                    p1_err_d = p1_req;
                    p2_err_d = p2_req;
                end
                default: state_d = S_TURN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_TURN;
            board_q  <= '0;
            turn_q   <= FIRST_PLAYER;
            cnt_q    <= '0;
            over_q   <= 1'b0;
            winner_q <= WIN_NONE;
            p1_ack_q <= 1'b0;
            p2_ack_q <= 1'b0;
            p1_err_q <= 1'b0;
            p2_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            cnt_q    <= cnt_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            p1_ack_q <= p1_ack_d;
            p2_ack_q <= p2_ack_d;
            p1_err_q <= p1_err_d;
            p2_err_q <= p2_err_d;
        end
    end

    assign p1_ack     = p1_ack_q;
    assign p2_ack     = p2_ack_q;
    assign p1_err     = p1_err_q;
    assign p2_err     = p2_err_q;
    assign board      = board_q;
    assign turn       = turn_q;
    assign move_count = cnt_q;
    assign game_over  = over_q;
    assign winner     = winner_q;

endmodule
